ir_fetch_assembler: RTL
=======================

Name: ir_fetch_assembler

Overview:
- Upstream stage of the 16-bit register: fetches two consecutive bytes from 8-bit memory, assembles one 16-bit word, drives I/E/FunSel of a downstream 16-bit register to load it.
- Also exposes the register's increment, decrement and clear functions through a single command port, so the sequencer only ever talks to this block.
- Sits between the control sequencer, the byte-wide memory and the instruction/address register.

Parameters:
- LITTLE_ENDIAN, 1, 1: first fetched byte → bits 7:0; 0: first byte → bits 15:8.
- MAX_WAIT, 15, maximum cycles MemRead may stay high without MemReady before abort (1..255).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin fetch at StartAddr; sampled only in IDLE.
- StartAddr  in  16  byte address of first byte.
- Cmd  in  2  direct command in IDLE when Start=0: 00 none, 01 increment, 10 decrement, 11 clear.
- MemData  in  8  memory read data, valid when MemReady=1.
- MemReady  in  1  memory data-valid strobe.
- MemAddr  out  16  byte address presented to memory.
- MemRead  out  1  read request.
- RegI  out  16  data to register I input.
- RegE  out  1  register enable.
- RegFunSel  out  2  register function select (00 dec, 01 inc, 10 load, 11 clear).
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle pulse, same cycle as RegE for a load.
- Error  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (synchronous): state=IDLE; MemAddr=0, MemRead=0, RegI=0, RegE=0, RegFunSel=00, Busy=0, Done=0, Error=0; byte latch and wait counter cleared. Reset overrides everything, including mid-fetch; no RegE is issued for an aborted fetch.
- States: IDLE, RD_FIRST, RD_SECOND, LOAD.
- IDLE:
  - Start=1 → MemAddr<=StartAddr, MemRead<=1, wait counter<=0, go to RD_FIRST.
  - Start has priority over Cmd.
  - Start=0 and Cmd≠00 → next cycle RegE=1 for exactly one cycle, RegFunSel = 01 (inc), 00 (dec) or 11 (clear); stay in IDLE; Busy stays 0; no Done.
- RD_FIRST:
  - MemReady=1 → latch MemData as byte0, MemAddr<=MemAddr+1 (16-bit wrap, FFFF→0000), counter<=0, go to RD_SECOND with MemRead held high.
  - Otherwise counter++.
- RD_SECOND:
  - MemReady=1 → MemRead<=0, RegI<=assembled word, go to LOAD.
  - Otherwise counter++.
- Word assembly: LITTLE_ENDIAN=1 → {byte1,byte0}; LITTLE_ENDIAN=0 → {byte0,byte1}.
- Timeout: in RD_FIRST/RD_SECOND, if counter reaches MAX_WAIT with MemReady still 0 → MemRead<=0, Error pulses next cycle, return to IDLE. RegE is not asserted and RegI is unchanged.
- LOAD: RegE=1, RegFunSel=10, Done=1 for one cycle; RegI is stable this cycle; next state IDLE.
- MemReady while MemRead=0 is ignored.
- Start/Cmd outside IDLE are ignored, not queued.
- Minimum fetch latency: Start sampled at edge N; zero-wait memory gives MemReady in cycles N+1 and N+2; LOAD/Done in cycle N+3; register updates at edge N+4.
- RegE is 0 in every cycle not listed above; RegFunSel returns to 00 when RegE=0.

Test Plan:
- Reset then idle → all outputs 0; Cmd=11 → one-cycle RegE=1, RegFunSel=11, Busy=0, Done=0.
- Start, StartAddr=0x0040, zero-wait memory returning 0x34 then 0x12, LITTLE_ENDIAN=1 → MemAddr 0x0040 then 0x0041; RegI=0x1234, RegE=1, RegFunSel=10, Done=1 in LOAD; Busy for 3 cycles.
- Same stimulus with LITTLE_ENDIAN=0 → RegI=0x3412.
- StartAddr=0xFFFF with 2 wait cycles per byte → second MemAddr=0x0000; MemRead held through the waits; Done 7 cycles after Start.
- MemReady never asserted, MAX_WAIT=15 → Error pulses once, MemRead drops, no RegE; then Start succeeds normally.
- Reset asserted in RD_SECOND → next cycle IDLE, all outputs 0, no RegE; Start together with Cmd=01 in IDLE → fetch begins and the increment is dropped.

Source files
------------

// File: rtl/ir_fetch_assembler.sv
// Fetches two bytes from byte-wide memory and loads them as one 16-bit word
// into the downstream register; also forwards inc/dec/clear commands to it.
module ir_fetch_assembler #(
  parameter bit          LITTLE_ENDIAN = 1'b1,
  parameter int unsigned MAX_WAIT      = 15
) (
  input  logic        Clock_i,
  input  logic        Reset_i,
  input  logic        Start_i,
  input  logic [15:0] StartAddr_i,
  input  logic [1:0]  Cmd_i,
  input  logic [7:0]  MemData_i,
  input  logic        MemReady_i,
  output logic [15:0] MemAddr_o,
  output logic        MemRead_o,
  output logic [15:0] RegI_o,
  output logic        RegE_o,
  output logic [1:0]  RegFunSel_o,
  output logic        Busy_o,
  output logic        Done_o,
  output logic        Error_o
);

  typedef enum logic [1:0] {
    IDLE, RD_FIRST, RD_SECOND, LOAD
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic [15:0] regi_q, regi_d;
  logic        rege_q, rege_d;
  logic [1:0]  fun_q, fun_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] word;
  logic        tmo;

  assign word = LITTLE_ENDIAN ? {MemData_i, byte0_q}
                              : {byte0_q, MemData_i};
  assign tmo  = (cnt_q == WAIT_LAST);

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      regi_q  <= '0;
      rege_q  <= 1'b0;
      fun_q   <= 2'b00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      byte0_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      regi_q  <= regi_d;
      rege_q  <= rege_d;
      fun_q   <= fun_d;
      done_q  <= done_d;
      err_q   <= err_d;
      byte0_q <= byte0_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    regi_d  = regi_q;
    rege_d  = 1'b0;
    fun_d   = 2'b00;
    done_d  = 1'b0;
    err_d   = 1'b0;
    byte0_d = byte0_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Start_i) begin
          addr_d  = StartAddr_i;
          rd_d    = 1'b1;
          cnt_d   = '0;
          state_d = RD_FIRST;
        end else if (Cmd_i != 2'b00) begin
          rege_d = 1'b1;
          // command 10 (dec) maps to funsel 00; inc/clear pass through
          fun_d  = (Cmd_i == 2'b10) ? 2'b00 : Cmd_i;
        end
      end
      RD_FIRST: begin
        if (MemReady_i) begin
          byte0_d = MemData_i;
          addr_d  = addr_q + 16'd1;
          cnt_d   = '0;
          state_d = RD_SECOND;
        end else if (tmo) begin
          rd_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RD_SECOND: begin
        if (MemReady_i) begin
          rd_d    = 1'b0;
          regi_d  = word;
          rege_d  = 1'b1;
          fun_d   = 2'b10;
          done_d  = 1'b1;
          state_d = LOAD;
        end else if (tmo) begin
          rd_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LOAD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign MemAddr_o   = addr_q;
  assign MemRead_o   = rd_q;
  assign RegI_o      = regi_q;
  assign RegE_o      = rege_q;
  assign RegFunSel_o = fun_q;
  assign Busy_o      = (state_q != IDLE);
  assign Done_o      = done_q;
  assign Error_o     = err_q;

endmodule
